// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          OPCODE_W   = 5;
    localparam logic [4:0]  HALT_OP    = 5'b00001;
    localparam logic [4:0]  NOP_OP     = 5'b00000;
    localparam int          SKID_DEPTH = 2;

    // Opcode occupies the top OPCODE_W bits of the instruction word.
    function automatic int opcode_lsb(input int instr_w);
        return instr_w - OPCODE_W;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying one instruction per beat.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
);
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [4:0]         out_opcode;

    modport master (
        output out_valid, out_instr, out_pc, out_opcode,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_instr, out_pc, out_opcode,
        output out_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {instr, pc} pairs while decode stalls.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [SKID_DEPTH];
    logic [W-1:0] mem_d [SKID_DEPTH];
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;

    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        do_pop = pop && (cnt_q != 2'd0);
        // Flush wins over a simultaneous push/pop; storage keeps stale data.
        if (flush) begin
            rd_d  = 1'b0;
            wr_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = ~wr_q;
            end
            if (do_pop) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + 2'(push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC generation, instruction-memory issue and skid-buffered hand-off to decode,
// with branch redirect and HALT-opcode stop.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic                 imem_en,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    instr_fetch_unit_if.master   dec,
    output logic                 halted
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam int OP_LSB  = opcode_lsb(INSTR_W);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              infl_epoch_q, infl_epoch_d;

    logic [ENTRY_W-1:0] head;
    logic [1:0]         count;
    logic               push, pop, flush;
    logic               issue;
    logic [ADDR_W-1:0]  issue_addr;
    logic [INSTR_W-1:0] head_instr;
    logic               out_valid;
    logic               handshake;
    logic               head_is_halt;
    logic [2:0]         occ_next;

    fetch_skid_buf #(.W(ENTRY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_rdata, pc_q - ADDR_W'(1)}),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count)
    );

    assign head_instr   = head[ENTRY_W-1 -: INSTR_W];
    assign out_valid    = (count != 2'd0);
    assign handshake    = out_valid && dec.out_ready;
    assign head_is_halt = (head_instr[OP_LSB +: OPCODE_W] == HALT_OP);

    // Space check counts this cycle's pop so a streaming decoder sees one word per cycle.
    assign occ_next = {1'b0, count} - 3'(handshake) + 3'(inflight_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inflight_d   = 1'b0;
        epoch_d      = epoch_q;
        infl_epoch_d = infl_epoch_q;
        issue        = 1'b0;
        issue_addr   = pc_q;
        flush        = 1'b0;
        push         = 1'b0;
        pop          = handshake;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                push = inflight_q && (infl_epoch_q == epoch_q);
                if (redirect_valid) begin
                    flush        = 1'b1;
                    push         = 1'b0;
                    epoch_d      = ~epoch_q;
                    issue        = 1'b1;
                    issue_addr   = redirect_pc;
                    pc_d         = redirect_pc + 1'b1;
                    inflight_d   = 1'b1;
                    infl_epoch_d = ~epoch_q;
                end else if (handshake && head_is_halt) begin
                    flush   = 1'b1;
                    push    = 1'b0;
                    epoch_d = ~epoch_q;
                    state_d = ST_HALT;
                end else if (occ_next < 3'd2) begin
                    issue        = 1'b1;
                    pc_d         = pc_q + 1'b1;
                    inflight_d   = 1'b1;
                    infl_epoch_d = epoch_q;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    flush   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            epoch_q      <= 1'b0;
            infl_epoch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            epoch_q      <= epoch_d;
            infl_epoch_q <= infl_epoch_d;
        end
    end

    assign imem_en        = issue;
    assign imem_addr      = issue_addr;
    assign halted         = (state_q == ST_HALT);
    assign dec.out_valid  = out_valid;
    assign dec.out_instr  = head_instr;
    assign dec.out_pc     = head[ADDR_W-1:0];
    assign dec.out_opcode = head_instr[OP_LSB +: OPCODE_W];

endmodule
